// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
// FSM encoding and data width, also used by uart_tx/uart_rx.
package uart_tx_sched_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// Combinational round-robin picker: rotate by ptr,
// priority-encode the lowest set bit, rotate the index back.
module uart_tx_sched_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    logic [2*N-2:0] dbl;
    logic [N-1:0]   rot;
    logic [PW-1:0]  sel;
    logic [PW:0]    sum;

    assign dbl = {req[N-2:0], req};
    assign any = |req;

    // rotate so that requester ptr lands at bit 0
    always_comb begin
        rot = '0;
        for (int s = 0; s < N; s++) begin
            if (ptr == PW'(s)) rot = dbl[s +: N];
        end
    end

    // lowest set bit of the rotated vector, mapped back to a requester
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) sel = PW'(i);
        end
        sum = {1'b0, sel} + {1'b0, ptr};
        if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
        gnt_idx = sum[PW-1:0];
        gnt_onehot = '0;
        if (|rot) gnt_onehot[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte
// producers, with a programmable idle gap between frames.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int GAP_BITS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         baud_tick_1x,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*UART_DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic [UART_DATA_W-1:0]       tx_data,
    output logic                         tx_start,
    input  logic                         tx_done,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         sched_busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int GW = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;

    sched_state_t state, state_nx;

    logic [IW-1:0]          rr_ptr;
    logic [GW-1:0]          gap_cnt;
    logic [GW:0]            gap_inc;
    logic                   gap_hit;
    logic [N_REQ-1:0]       pick_onehot;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;
    logic                   accept;
    logic [UART_DATA_W-1:0] req_byte [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
        assign req_byte[i] = req_data[UART_DATA_W*i +: UART_DATA_W];
    end

    uart_tx_sched_rr_pick #(
        .N (N_REQ),
        .PW(IW)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .gnt_onehot(pick_onehot),
        .gnt_idx   (pick_idx),
        .any       (pick_any)
    );

    assign accept     = (state == ST_IDLE) && pick_any;
    assign req_ready  = accept ? pick_onehot : '0;
    assign sched_busy = (state != ST_IDLE);

    // the tick being counted is included when comparing to GAP_BITS
    assign gap_inc = {1'b0, gap_cnt} + (GW+1)'(1);
    assign gap_hit = gap_inc >= (GW+1)'(GAP_BITS);

    // next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (pick_any) state_nx = ST_START;
            ST_START: state_nx = ST_WAIT;
            ST_WAIT: begin
                if (tx_done) state_nx = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (baud_tick_1x && gap_hit) state_nx = ST_IDLE;
            end
            default:  state_nx = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // accept: latch byte and winner, advance pointer, fire start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_start <= 1'b0;
            tx_data  <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            tx_start <= accept;
            if (accept) begin
                tx_data  <= req_byte[pick_idx];
                grant_id <= pick_idx;
                rr_ptr   <= (pick_idx == IW'(N_REQ - 1)) ?
                            '0 : pick_idx + IW'(1);
            end
        end
    end

    // inter-frame gap counter, saturating
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (state == ST_WAIT && tx_done) begin
            gap_cnt <= '0;
        end else if (state == ST_GAP && baud_tick_1x) begin
            gap_cnt <= gap_hit ? GW'(GAP_BITS) : gap_inc[GW-1:0];
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus random traffic
// checked against a round-robin / gap-timing reference model.
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int GB = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           baud_tick_1x;
    logic           tx_done;
    logic           tx_start;
    logic           sched_busy;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*8-1:0] req_data;
    logic [7:0]     tx_data;
    logic [1:0]     grant_id;

    int checks = 0;
    int errors = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .N_REQ   (N),
        .GAP_BITS(GB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_tick_1x(baud_tick_1x),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .sched_busy  (sched_busy)
    );

    // reference: first valid requester scanning upward from m_ptr
    function automatic int model_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        tx_done = 1'b0;
        baud_tick_1x = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    // one full frame: accept, start, WAIT of dly cycles, gap of GB ticks
    task automatic run_frame(input logic [N-1:0] v, input logic [N-1:0] v2,
                             input logic [N*8-1:0] d, input int dly,
                             input int tper, output int g);
        logic [N-1:0] exp_r;
        logic [7:0]   exp_b;
        int           ticks;
        int           cyc;
        bit           bad;
        req_valid = v;
        req_data = d;
        #1;
        g = model_pick(v);
        exp_r = '0;
        exp_r[g] = 1'b1;
        exp_b = d[8*g +: 8];
        checks++;
        if (req_ready !== exp_r) begin
            errors++;
            $display("FAIL accept_ready got %b want %b", req_ready, exp_r);
        end
        tick();
        req_valid = v2;
        m_ptr = (g + 1) % N;
        #1;
        checks++;
        if (tx_start !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse got %b want 1", tx_start);
        end
        checks++;
        if (tx_data !== exp_b) begin
            errors++;
            $display("FAIL tx_data got %h want %h", tx_data, exp_b);
        end
        checks++;
        if (grant_id !== 2'(g)) begin
            errors++;
            $display("FAIL grant_id got %0d want %0d", grant_id, g);
        end
        checks++;
        if (sched_busy !== 1'b1 || req_ready !== '0) begin
            errors++;
            $display("FAIL start_state busy %b ready %b want 1 0000",
                     sched_busy, req_ready);
        end
        tick();
        bad = 1'b0;
        for (int k = 0; k < dly; k++) begin
            baud_tick_1x = (k == 1);
            tx_done = (k == dly - 1);
            #1;
            if (tx_start !== 1'b0 || req_ready !== '0 ||
                sched_busy !== 1'b1 || tx_data !== exp_b) bad = 1'b1;
            tick();
        end
        tx_done = 1'b0;
        baud_tick_1x = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL wait_phase got protocol violation want none");
        end
        bad = 1'b0;
        ticks = 0;
        cyc = 0;
        while (ticks < GB && cyc < 5000) begin
            baud_tick_1x = ((cyc % tper) == tper - 1);
            #1;
            if (tx_start !== 1'b0 || req_ready !== '0 ||
                sched_busy !== 1'b1 || tx_data !== exp_b) bad = 1'b1;
            if (baud_tick_1x) ticks++;
            tick();
            cyc++;
        end
        baud_tick_1x = 1'b0;
        #1;
        checks++;
        if (bad || ticks < GB) begin
            errors++;
            $display("FAIL gap_phase got early ready/idle want busy for %0d ticks",
                     GB);
        end
        checks++;
        if (sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_gap got busy %b want 0", sched_busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_tx_data got %h want 00", tx_data);
        end
        checks++;
        if (tx_start !== 1'b0) begin
            errors++;
            $display("FAIL rst_tx_start got %b want 0", tx_start);
        end
        checks++;
        if (req_ready !== '0) begin
            errors++;
            $display("FAIL rst_req_ready got %b want 0000", req_ready);
        end
        checks++;
        if (grant_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_grant_id got %0d want 0", grant_id);
        end
        checks++;
        if (sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got %b want 0", sched_busy);
        end
    endtask

    task automatic test_single();
        int g;
        do_reset();
        run_frame(4'b0100, 4'b0000, 32'h00AB_0000, 160, 80, g);
    endtask

    task automatic test_all_contend();
        int g;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_frame(4'b1111, 4'b1111, $urandom, 20, 6, g);
            checks++;
            if (grant_id !== 2'(i % N)) begin
                errors++;
                $display("FAIL contend_order got %0d want %0d",
                         grant_id, i % N);
            end
        end
    endtask

    task automatic test_gap();
        int g;
        do_reset();
        run_frame(4'b0001, 4'b0010, $urandom, 50, 80, g);
        run_frame(4'b0010, 4'b0000, $urandom, 10, 80, g);
    endtask

    task automatic test_withdraw();
        int g;
        do_reset();
        run_frame(4'b1011, 4'b1000, $urandom, 30, 5, g);
        run_frame(4'b1000, 4'b0000, $urandom, 10, 5, g);
        checks++;
        if (grant_id !== 2'd3) begin
            errors++;
            $display("FAIL withdraw_grant got %0d want 3", grant_id);
        end
    endtask

    task automatic test_reset_mid_wait();
        int g;
        do_reset();
        req_data = $urandom;
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL pre_reset_ready got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (tx_data !== 8'h00 || tx_start !== 1'b0 || req_ready !== '0 ||
            grant_id !== 2'd0 || sched_busy !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset got data %h start %b ready %b id %0d busy %b want 00 0 0000 0 0",
                     tx_data, tx_start, req_ready, grant_id, sched_busy);
        end
        m_ptr = 0;
        run_frame(4'b0110, 4'b0000, $urandom, 12, 4, g);
        checks++;
        if (grant_id !== 2'd1) begin
            errors++;
            $display("FAIL ptr_restart got %0d want 1", grant_id);
        end
    endtask

    task automatic test_spurious();
        int g;
        do_reset();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        #1;
        checks++;
        if (sched_busy !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_tx_done got busy %b start %b want 0 0",
                     sched_busy, tx_start);
        end
        baud_tick_1x = 1'b1;
        tick();
        baud_tick_1x = 1'b0;
        #1;
        checks++;
        if (sched_busy !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_tick got busy %b start %b want 0 0",
                     sched_busy, tx_start);
        end
        run_frame(4'b0100, 4'b0000, $urandom, 8, 3, g);
    endtask

    task automatic test_random();
        int g;
        logic [N-1:0] v;
        logic [N-1:0] v2;
        v = 4'($urandom_range(1, 15));
        for (int i = 0; i < 30; i++) begin
            v2 = 4'($urandom_range(0, 15));
            run_frame(v, v2, $urandom, $urandom_range(3, 40),
                      $urandom_range(1, 12), g);
            v = (v2 != '0) ? v2 : 4'($urandom_range(1, 15));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_contend();
        test_gap();
        test_withdraw();
        test_reset_mid_wait();
        test_spurious();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one `uart_tx` transmitter among `N_REQ` byte producers. It arbitrates, latches the winning byte, and pulses the transmitter's start. It waits for frame completion, then enforces a programmable inter-frame idle gap, counted in bit times from `baud_gen_16x`'s `baud_tick_1x`. It sits between on-chip producers (command responder, status reporter, debug tap) and the single TX line.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `GAP_BITS`, default 2: idle bit times inserted after each frame's `tx_done`; 0 disables the gap.

Ports:
- `clk`: input, 1 bit. System clock.
- `rst_n`: input, 1 bit. Reset, synchronous and active-low.
- `baud_tick_1x`: input, 1 bit. One-cycle pulse per bit time, from `baud_gen_16x`.
- `req_valid`: input, `N_REQ` bits. Per-requester "byte available".
- `req_data`: input, `N_REQ*8` bits. Requester i's byte is in `[8*i+7:8*i]`.
- `req_ready`: output, `N_REQ` bits. One-hot accept pulse; a transfer occurs when valid and ready are both high.
- `tx_data`: output, 8 bits. Latched byte to `uart_tx`; held stable from START until the next accept.
- `tx_start`: output, 1 bit. One-cycle start pulse to `uart_tx`.
- `tx_done`: input, 1 bit. One-cycle pulse from `uart_tx` after the stop bit.
- `grant_id`: output, `$clog2(N_REQ)` bits. Index of the current or last granted requester.
- `sched_busy`: output, 1 bit. High in every state except IDLE.

## Operation

- FSM states: IDLE, START, WAIT, GAP.
- **IDLE:** if any `req_valid` is set, pick winner g by round-robin starting at `rr_ptr`.
  - Same cycle: assert `req_ready[g]=1`.
  - On the next edge: latch `tx_data`, set `grant_id=g`, set `rr_ptr=(g+1) mod N_REQ`, go to START.
- **START:** `tx_start=1` for exactly this cycle; go to WAIT.
- **WAIT:** hold until `tx_done`.
  - If `tx_done` and `GAP_BITS>0`: go to GAP and clear `gap_cnt`.
  - If `tx_done` and `GAP_BITS=0`: go to IDLE.
- **GAP:** increment `gap_cnt` on each `baud_tick_1x`. When `gap_cnt` reaches `GAP_BITS` (the count includes the tick), go to IDLE.
- Requests are accepted only in IDLE. `req_ready` is 0 in all other states.
- A requester must hold `req_valid` and `req_data` until accepted. Deasserting before acceptance withdraws the request without error.
- If only one requester is valid, it wins regardless of `rr_ptr`.
- A requester that wins is lowest priority on the next arbitration, so there is no starvation. Maximum wait is `N_REQ-1` frames.
- A `tx_done` seen outside WAIT is ignored.
- A `baud_tick_1x` seen outside GAP is ignored.
- Widths:
  - `gap_cnt` is `$clog2(GAP_BITS+1)` bits, minimum 1, and saturates, never wraps.
  - `rr_ptr` wraps from `N_REQ-1` to 0.

## Timing

- Reset (synchronous, `rst_n=0` sampled at a `clk` edge): state=IDLE, `rr_ptr=0`, `gap_cnt=0`, `tx_data=8'h00`, `tx_start=0`, `req_ready=0`, `grant_id=0`, `sched_busy=0`.
- Reset mid-frame aborts the schedule immediately. The in-flight `uart_tx` frame is not the scheduler's concern; `uart_tx` shares `rst_n`.
- `req_ready` is combinational from `req_valid`, state and `rr_ptr`, with no other combinational path.
- `tx_start` and `tx_data` are registered.
- Latency from a `req_valid` rising edge in IDLE to `tx_start`:
  - accept cycle 0 (`req_ready` high);
  - START on cycle 1 (`tx_start` high).
- From `tx_done`: GAP is entered 1 cycle later. IDLE is reached on the cycle after the `GAP_BITS`-th `baud_tick_1x`, so new acceptance is possible then.
- Minimum `req_ready` spacing with `GAP_BITS=0` is 3 cycles plus frame time.

## Structure

- Shared include `uart_defs.vh`: FSM state encodings (2-bit: IDLE=0, START=1, WAIT=2, GAP=3) and `UART_DATA_W=8`. These are reused by `uart_tx` and `uart_rx`.
- Sub-module `rr_pick`: purely combinational round-robin picker.
  - Inputs: `req[N-1:0]`, `ptr`.
  - Outputs: `gnt_onehot`, `gnt_idx`, `any`.
  - Implemented as a rotate, priority-encode, then rotate back.
  - Unit-testable on its own.
- The top holds the FSM, `rr_ptr`, `gap_cnt`, the data latch, and the output registers.

## Test plan

1. **Single requester:** `N_REQ=4`, `req_valid=4'b0100`, byte 8'hAB; `uart_tx` model asserts `tx_done` 160 cycles after start.
   - `req_ready=4'b0100` for 1 cycle.
   - `tx_start` pulses 1 cycle later with `tx_data=8'hAB`.
   - `grant_id=2`.
2. **All contend:** `req_valid=4'b1111` continuously.
   - Grant order is 0,1,2,3,0.
   - Exactly one `tx_start` per `tx_done`.
3. **Gap enforcement:** `GAP_BITS=2`, `baud_tick_1x` every 80 cycles, next request pending at `tx_done`.
   - `req_ready` stays 0 until the cycle after the second tick following `tx_done`.
   - `sched_busy=1` throughout that interval.
4. **Withdrawn request:** requester 1 drops valid during WAIT of requester 0's frame while requester 3 is valid.
   - Next grant is 3.
   - No `req_ready[1]` pulse.
5. **Reset mid-WAIT:** `rst_n=0` for 1 cycle.
   - All outputs match reset values on the next edge.
   - A subsequent `req_valid=4'b0010` is granted with `rr_ptr` restarted at 0.
6. **Spurious inputs:** `tx_done` pulsed in IDLE and `baud_tick_1x` pulsed in WAIT.
   - No state change.
   - No extra `tx_start`.
